onehot_rr_arbiter: RTL

Round-robin arbiter for `N` requesters. It issues a registered one-hot grant vector `gnt`, qualified by `gnt_vld`, and holds each grant until the consumer signals `done`. It is the upstream producer for the one-hot grant checker: whenever `gnt_vld` is 1, `gnt` is guaranteed to be `$onehot`; whenever `gnt_vld` is 0, `gnt` is all-zero.

---
 rtl/onehot_rr_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant, held until done.
// Optional grant timeout is compiled in with macro RR_ARB_TIMEOUT_EN.
module onehot_rr_arbiter #(
  parameter int N        = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_i,
  input  logic                 done_i,
  output logic                 gnt_vld_o,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] gnt_idx_o,
  output logic                 timeout_o
);

  localparam int IW = $clog2(N);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  if ((N < 2) || (N > 32) || (MAX_HOLD < 2)) begin : g_bad_param
    $error("onehot_rr_arbiter: illegal N or MAX_HOLD");
  end

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          vld_q, vld_d;

  logic [2*N-1:0] req2_s;
  logic [N-1:0]   rot_s;
  logic [IW-1:0]  pos_s;
  logic           found_s;
  logic [IW:0]    sum_s;
  logic [IW-1:0]  sel_idx_s;
  logic [IW-1:0]  ptr_inc_s;

  // Rotating the doubled request vector by ptr puts requester ptr at bit 0.
  assign req2_s    = {req_i, req_i} >> ptr_q;
  assign rot_s     = req2_s[N-1:0];
  assign found_s   = |rot_s;
  assign sum_s     = {1'b0, ptr_q} + {1'b0, pos_s};
  assign sel_idx_s = (sum_s >= (IW+1)'(N)) ? IW'(sum_s - (IW+1)'(N)) : sum_s[IW-1:0];
  assign ptr_inc_s = (idx_q == IW'(N-1)) ? {IW{1'b0}} : idx_q + IW'(1);

  // Lowest set bit of the rotated request vector
  always_comb begin
    pos_s = {IW{1'b0}};
    for (int k = N-1; k >= 0; k--) begin
      if (rot_s[k]) begin
        pos_s = IW'(k);
      end else begin
      end
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD+1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  // Next-state logic for the IDLE/BUSY grant FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_BUSY;
          vld_d   = 1'b1;
          idx_d   = sel_idx_s;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << sel_idx_s;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d  = HW'(1);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
`ifdef RR_ARB_TIMEOUT_EN
        if (done_i || (hold_q == HW'(MAX_HOLD))) begin
          timeout_d = ~done_i;
          hold_d    = {HW{1'b0}};
`else
        if (done_i) begin
`endif
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          gnt_d   = {N{1'b0}};
          idx_d   = {IW{1'b0}};
          ptr_d   = ptr_inc_s;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_d = hold_q + HW'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        gnt_d   = {N{1'b0}};
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= {IW{1'b0}};
      gnt_q   <= {N{1'b0}};
      idx_q   <= {IW{1'b0}};
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Hold counter and timeout pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= {HW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gnt_vld_o = vld_q;
  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;

endmodule
